// File: rtl/pulse_req_ctrl.sv
// Pending-event counter feeding a request/acknowledge handshake with timed retry and a sticky error state.
// Latency: evt_in at n gives req_out at n+2 from empty idle; done_pulse one cycle after ack_in; no backpressure, excess events are dropped and flagged.
module pulse_req_ctrl #(
  parameter int PEND_W    = 4,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_in,
  input  logic              ack_in,
  input  logic              err_clr,
  output logic              req_out,
  output logic              done_pulse,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow,
  output logic              err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, ERR} state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [RTY_W-1:0] retry, retry_nxt;
  logic             ack_hit;
  logic             full;
  logic             drop;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    retry_nxt = retry;
    ack_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_cnt != '0) state_nxt = SEND;
      end
      SEND: begin
        state_nxt = WAIT;
        timer_nxt = '0;
      end
      WAIT: begin
        timer_nxt = timer + 1'b1;
        // an ack in the expiry cycle still completes the request
        if (ack_in) begin
          ack_hit   = 1'b1;
          retry_nxt = '0;
          state_nxt = IDLE;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          if (retry < RTY_W'(MAX_RETRY)) begin
            retry_nxt = retry + 1'b1;
            state_nxt = SEND;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      ERR: begin
        if (err_clr) begin
          retry_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign full = (pend_cnt == '1);
  assign drop = evt_in && !ack_hit && full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      timer      <= '0;
      retry      <= '0;
      pend_cnt   <= '0;
      overflow   <= 1'b0;
      req_out    <= 1'b0;
      done_pulse <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      retry    <= retry_nxt;
      // a simultaneous event and acknowledge cancel out
      if (evt_in && !ack_hit && !full) pend_cnt <= pend_cnt + 1'b1;
      else if (ack_hit && !evt_in)     pend_cnt <= pend_cnt - 1'b1;
      overflow   <= (overflow && !err_clr) || drop;
      req_out    <= (state_nxt == SEND);
      done_pulse <= ack_hit;
      busy       <= (state_nxt != IDLE);
      err        <= (state_nxt == ERR);
    end
  end

endmodule

// File: tb/tb_pulse_req_ctrl.sv
// Randomized and directed stimulus for pulse_req_ctrl, checked every cycle against a timestamp-based reference model.
module tb_pulse_req_ctrl;

  localparam int PEND_W    = 4;
  localparam int TIMEOUT   = 64;
  localparam int MAX_RETRY = 3;
  localparam int PEND_MAX  = (1 << PEND_W) - 1;

  logic              clk = 1'b0;
  logic              rst, evt_in, ack_in, err_clr;
  logic              req_out, done_pulse, busy, overflow, err;
  logic [PEND_W-1:0] pend_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model: outputs for the current cycle plus timestamps
  int m_pend, req_t, sends;
  bit m_ovf, m_req, m_done, m_wait, m_inerr;

  pulse_req_ctrl #(.PEND_W(PEND_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .evt_in(evt_in), .ack_in(ack_in), .err_clr(err_clr),
    .req_out(req_out), .done_pulse(done_pulse), .busy(busy), .pend_cnt(pend_cnt),
    .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit a, input bit c);
    bit acc, expire, ovf_set, n_req;
    int old_pend;
    if (!r) begin
      m_pend = 0; m_ovf = 0; m_req = 0; m_done = 0; m_wait = 0; m_inerr = 0;
      sends = 0; req_t = 0;
      return;
    end
    acc      = m_wait && a;
    expire   = m_wait && !acc && (cyc - req_t == TIMEOUT);
    old_pend = m_pend;
    ovf_set  = 0;
    if (e && !acc) begin
      if (m_pend == PEND_MAX) ovf_set = 1;
      else m_pend++;
    end else if (acc && !e) begin
      m_pend--;
    end
    m_ovf = (m_ovf && !c) || ovf_set;
    n_req = 0;
    if (m_req) begin
      m_wait = 1;
      req_t  = cyc;
    end else if (m_wait) begin
      if (acc) begin
        m_wait = 0;
        sends  = 0;
      end else if (expire) begin
        m_wait = 0;
        if (sends <= MAX_RETRY) n_req = 1;
        else m_inerr = 1;
      end
    end else if (m_inerr) begin
      if (c) begin
        m_inerr = 0;
        sends   = 0;
      end
    end else if (old_pend != 0) begin
      n_req = 1;
    end
    if (n_req) sends++;
    m_req  = n_req;
    m_done = acc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, evt_in, ack_in, err_clr);
    cyc++;
    #1;
    chk("req_out",    req_out,    m_req);
    chk("done_pulse", done_pulse, m_done);
    chk("busy",       busy,       m_req || m_wait || m_inerr);
    chk("pend_cnt",   pend_cnt,   m_pend);
    chk("overflow",   overflow,   m_ovf);
    chk("err",        err,        m_inerr);
  endtask

  task automatic cyc1(input bit e, input bit a, input bit c);
    evt_in = e; ack_in = a; err_clr = c;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc1(0, 0, 0);
    cyc1(0, 0, 0);
    rst = 1'b1;
  endtask

  task automatic run_rand(input int n, input int p_evt, input int p_ack, input int p_clr,
                          input int p_rst, input int dly);
    int cd = 0;
    for (int i = 0; i < n; i++) begin
      bit a;
      a = ($urandom_range(99) < p_ack);
      if (dly > 0) begin
        if (m_req) cd = dly;
        else if (cd > 0) begin
          cd--;
          if (cd == 0) a = 1;
        end
      end
      rst = ($urandom_range(999) >= p_rst);
      cyc1($urandom_range(99) < p_evt, a, $urandom_range(99) < p_clr);
    end
    rst = 1'b1;
  endtask

  initial begin
    int reqs, dones, last;
    int rq[$];
    rst = 1'b0; evt_in = 0; ack_in = 0; err_clr = 0;

    // reset state
    do_reset();
    chk("rst_req", req_out, 0);
    chk("rst_pend", pend_cnt, 0);

    // single event with ack five cycles after the request
    cyc1(1, 0, 0);
    chk("single_pend1", pend_cnt, 1);
    cyc1(0, 0, 0);
    chk("single_req_n2", req_out, 1);
    for (int k = 0; k < 5; k++) cyc1(0, 0, 0);
    cyc1(0, 1, 0);
    chk("single_done", done_pulse, 1);
    chk("single_pend0", pend_cnt, 0);
    chk("single_idle", busy, 0);

    // burst of 20 events saturates, then drained by acks
    do_reset();
    reqs = 0; dones = 0;
    for (int k = 0; k < 20; k++) begin
      cyc1(1, 0, 0);
      reqs += req_out;
    end
    chk("burst_sat", pend_cnt, PEND_MAX);
    chk("burst_ovf", overflow, 1);
    for (int k = 0; k < 80; k++) begin
      cyc1(0, 1, 0);
      reqs  += req_out;
      dones += done_pulse;
    end
    chk("burst_reqs", reqs, PEND_MAX);
    chk("burst_dones", dones, PEND_MAX);
    chk("burst_empty", pend_cnt, 0);

    // no ack: retries then error, err_clr resumes
    do_reset();
    cyc1(1, 0, 0);
    for (int k = 0; k < 300; k++) begin
      cyc1(0, 0, 0);
      if (req_out) rq.push_back(cyc);
    end
    chk("retry_count", rq.size(), MAX_RETRY + 1);
    last = -1;
    foreach (rq[i]) begin
      if (i > 0) chk("retry_gap", rq[i] - last, TIMEOUT + 1);
      last = rq[i];
    end
    chk("retry_err", err, 1);
    cyc1(0, 0, 1);
    chk("clr_err", err, 0);
    cyc1(0, 0, 0);
    chk("clr_resume", req_out, 1);

    // ack exactly on the expiry cycle
    do_reset();
    cyc1(1, 0, 0);
    cyc1(0, 0, 0);
    for (int k = 0; k < TIMEOUT; k++) cyc1(0, 0, 0);
    cyc1(0, 1, 0);
    chk("edge_done", done_pulse, 1);
    chk("edge_noretry", req_out, 0);

    // event coincident with ack at pend_cnt=3
    do_reset();
    for (int k = 0; k < 3; k++) cyc1(1, 0, 0);
    cyc1(1, 1, 0);
    chk("coinc_pend", pend_cnt, 3);
    chk("coinc_done", done_pulse, 1);

    // reset while waiting with five pending events
    do_reset();
    for (int k = 0; k < 5; k++) cyc1(1, 0, 0);
    chk("wait_pend5", pend_cnt, 5);
    rst = 1'b0;
    cyc1(0, 0, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pend", pend_cnt, 0);
    rst = 1'b1;
    cyc1(0, 1, 0);
    cyc1(0, 1, 0);
    chk("stray_ack", done_pulse, 0);

    // randomized traffic
    run_rand(3000, 30, 20, 5, 0, 0);
    run_rand(3000, 10, 0, 2, 0, 0);
    run_rand(3000, 50, 0, 3, 2, 7);
    run_rand(3000, 70, 40, 10, 5, 0);
    run_rand(2000, 5, 1, 1, 1, 63);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pulse_req_ctrl.md
PULSE_REQ_CTRL -- requirements
Module: pulse_req_ctrl

Interface
REQ-001 SHALL have parameter PEND_W, default 4: width of the pending-event counter.
REQ-002 SHALL have parameter TIMEOUT, default 64: WAIT cycles without ack before a retry.
REQ-003 SHALL have parameter MAX_RETRY, default 3: number of re-sends allowed before the error state.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port evt_in, input, 1 bit: one-cycle pulse, one event per cycle high.
REQ-007 SHALL have port ack_in, input, 1 bit: one-cycle acknowledge pulse from the return pulse synchronizer.
REQ-008 SHALL have port err_clr, input, 1 bit: one-cycle clear of err and overflow.
REQ-009 SHALL have port req_out, output, 1 bit: registered one-cycle request pulse to the forward pulse synchronizer.
REQ-010 SHALL have port done_pulse, output, 1 bit: registered one-cycle pulse per acknowledged request.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port pend_cnt, output, PEND_W bits: events not yet acknowledged.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, an event was dropped.
REQ-014 SHALL have port err, output, 1 bit: sticky flag, retries exhausted.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, WAIT, ERR.
REQ-016 SHALL increment pend_cnt on a registered basis for each cycle evt_in=1.
REQ-017 SHALL, when pend_cnt=2^PEND_W-1 and no decrement occurs in that cycle, drop evt_in, hold pend_cnt and set overflow.
REQ-018 SHALL, when evt_in=1 and an ack decrement occur in the same cycle, leave pend_cnt unchanged and leave overflow untouched.
REQ-019 SHALL transition IDLE -> SEND on the cycle after IDLE observes pend_cnt!=0; evt_in at cycle n into an empty idle block gives pend_cnt=1 at n+1 and req_out=1 at n+2.
REQ-020 SHALL assert req_out for exactly the one cycle spent in SEND, then transition SEND -> WAIT, clearing the timeout timer.
REQ-021 SHALL, in WAIT with ack_in=1 at cycle m, assert done_pulse at m+1, decrement pend_cnt at m+1, clear the retry counter and return to IDLE at m+1.
REQ-022 SHALL guarantee at least 2 idle cycles between consecutive req_out pulses, so that forward toggles stay separable.
REQ-023 SHALL, in WAIT, increment the timer each cycle; on reaching TIMEOUT cycles without ack, go to SEND if retry<MAX_RETRY (retry+1, pend_cnt unchanged), else go to ERR.
REQ-024 SHALL give ack_in priority over timeout expiry when both occur in the same cycle.
REQ-025 SHALL treat an ack arriving after a retry as acknowledging the outstanding request; that ack is counted once only.
REQ-026 SHALL ignore ack_in in IDLE, SEND and ERR, with no effect on any output.
REQ-027 SHALL, in ERR, hold err=1 and req_out=0, and keep counting evt_in per REQ-016/017.
REQ-028 SHALL, on err_clr in ERR, clear err, overflow and retry and go to IDLE next cycle; pending events resume.
REQ-029 SHALL, on err_clr outside ERR, clear overflow only.

Reset
REQ-030 SHALL, with rst=0 at a clock edge, force state=IDLE, pend_cnt=0, timer=0, retry=0, and req_out=done_pulse=busy=overflow=err=0.
REQ-031 SHALL let reset mid-operation discard the outstanding request and all pending events.
REQ-032 SHALL ignore ack_in during reset and in the first cycle after reset release.

Verification
REQ-033 Single event: evt_in at n, ack_in 5 cycles after req_out -> req_out at n+2, done_pulse one cycle after ack, pend_cnt 1 -> 0, busy low after.
REQ-034 Burst of 20 evt_in pulses, PEND_W=4, no ack -> pend_cnt saturates at 15 and overflow=1; then 15 acks -> 15 req_out/done_pulse pairs and pend_cnt=0.
REQ-035 No ack, TIMEOUT=64, MAX_RETRY=3 -> 4 req_out pulses spaced 65 cycles apart, then err=1; err_clr -> req_out resumes 2 cycles later.
REQ-036 ack_in on the exact timeout cycle -> no retry pulse, done_pulse=1 next cycle.
REQ-037 evt_in coincident with an ack decrement at pend_cnt=3 -> pend_cnt stays 3.
REQ-038 rst=0 while in WAIT with pend_cnt=5 -> all outputs 0 next cycle; a subsequent stray ack_in -> no done_pulse.
